// File: rtl/im_hit_collector.sv
// im_hit_collector
// Downstream stage of the boost IM threshold test. Remembers which SNP pair
// is currently inside the interaction-measure generator, pairs it with the
// 1-bit significance result, queues significant pairs in a show-ahead FIFO
// and streams them out with valid/ready. Also keeps tested/hit/drop
// statistics and raises done_out once the scan has fully drained.

module im_hit_collector #(
  parameter int IDX_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            issue_valid,
  input  logic [IDX_WIDTH-1:0]            issue_idx_a,
  input  logic [IDX_WIDTH-1:0]            issue_idx_b,
  input  logic                            result_in,
  input  logic                            result_valid_in,
  input  logic                            scan_done_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [IDX_WIDTH-1:0]            out_idx_a,
  output logic [IDX_WIDTH-1:0]            out_idx_b,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic [CNT_WIDTH-1:0]            tested_count,
  output logic [CNT_WIDTH-1:0]            hit_count,
  output logic [CNT_WIDTH-1:0]            drop_count,
  output logic                            overflow,
  output logic                            proto_err,
  output logic                            done_out
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = $clog2(FIFO_DEPTH+1);
  localparam int ENTRY_W = 2 * IDX_WIDTH;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [IDX_WIDTH-1:0] latA_q, latA_d;
  logic [IDX_WIDTH-1:0] latB_q, latB_d;

  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
  logic [OCC_W-1:0]     fifoCount_q, fifoCount_d;

  logic [CNT_WIDTH-1:0] tested_q, tested_d;
  logic [CNT_WIDTH-1:0] hit_q, hit_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic                 overflow_q, overflow_d;
  logic                 protoErr_q, protoErr_d;
  logic                 donePending_q, donePending_d;

  logic accept;
  logic protoViol;
  logic fifoEmpty;
  logic fifoFull;
  logic pushReq;
  logic pushEn;
  logic popEn;
  logic dropEn;

  // Pending tracker: pairs each result with the indices latched at issue time
  always_comb begin
    state_d   = state_q;
    latA_d    = latA_q;
    latB_d    = latB_q;
    accept    = 1'b0;
    protoViol = 1'b0;
    if (state_q == IDLE) begin
      if (result_valid_in) begin
        protoViol = 1'b1;
      end
      if (issue_valid) begin
        state_d = PENDING;
        latA_d  = issue_idx_a;
        latB_d  = issue_idx_b;
      end
    end else begin
      if (result_valid_in) begin
        accept = 1'b1;
        if (issue_valid) begin
          latA_d = issue_idx_a;
          latB_d = issue_idx_b;
        end else begin
          state_d = IDLE;
        end
      end else if (issue_valid) begin
        protoViol = 1'b1;
      end
    end
  end

  // FIFO control: a full FIFO still takes a push when the head leaves that cycle
  always_comb begin
    fifoEmpty = (fifoCount_q == '0);
    fifoFull  = (fifoCount_q == OCC_W'(FIFO_DEPTH));
    pushReq   = accept & result_in;
    popEn     = ~fifoEmpty & out_ready;
    pushEn    = pushReq & (~fifoFull | popEn);
    dropEn    = pushReq & fifoFull & ~popEn;

    wrPtr_d     = pushEn ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d     = popEn  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    fifoCount_d = fifoCount_q;
    if (pushEn && !popEn) begin
      fifoCount_d = fifoCount_q + OCC_W'(1);
    end else if (popEn && !pushEn) begin
      fifoCount_d = fifoCount_q - OCC_W'(1);
    end
  end

  // Statistics, sticky flags and end-of-scan bookkeeping
  always_comb begin
    tested_d      = tested_q;
    hit_d         = hit_q;
    drop_d        = drop_q;
    overflow_d    = overflow_q | dropEn;
    protoErr_d    = protoErr_q | protoViol;
    donePending_d = donePending_q;
    if (accept && !(&tested_q)) begin
      tested_d = tested_q + CNT_WIDTH'(1);
    end
    if (pushReq && !(&hit_q)) begin
      hit_d = hit_q + CNT_WIDTH'(1);
    end
    if (dropEn && !(&drop_q)) begin
      drop_d = drop_q + CNT_WIDTH'(1);
    end
    if (scan_done_in) begin
      donePending_d = 1'b1;
    end else if (issue_valid) begin
      donePending_d = 1'b0;
    end
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      latA_q        <= '0;
      latB_q        <= '0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      fifoCount_q   <= '0;
      tested_q      <= '0;
      hit_q         <= '0;
      drop_q        <= '0;
      overflow_q    <= 1'b0;
      protoErr_q    <= 1'b0;
      donePending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      latA_q        <= latA_d;
      latB_q        <= latB_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      fifoCount_q   <= fifoCount_d;
      tested_q      <= tested_d;
      hit_q         <= hit_d;
      drop_q        <= drop_d;
      overflow_q    <= overflow_d;
      protoErr_q    <= protoErr_d;
      donePending_q <= donePending_d;
    end
  end

  // Hit storage; contents are don't-care until the count covers them
  always_ff @(posedge clk) begin
    if (pushEn && !rst) begin
      mem_q[wrPtr_q] <= {latA_q, latB_q};
    end
  end

  // Show-ahead outputs come straight from registered state
  always_comb begin
    out_valid    = ~fifoEmpty;
    out_idx_a    = mem_q[rdPtr_q][ENTRY_W-1:IDX_WIDTH];
    out_idx_b    = mem_q[rdPtr_q][IDX_WIDTH-1:0];
    fifo_count   = fifoCount_q;
    tested_count = tested_q;
    hit_count    = hit_q;
    drop_count   = drop_q;
    overflow     = overflow_q;
    proto_err    = protoErr_q;
    done_out     = donePending_q & (state_q == IDLE) & fifoEmpty;
  end

endmodule

// File: tb/tb_im_hit_collector.sv
// Testbench for im_hit_collector: a table of single-cycle vectors followed
// by hand-written sequences for double issue, done handling, overflow and
// mid-operation reset.

module tb_im_hit_collector;

  localparam int IW = 16;
  localparam int FD = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          issueValid;
  logic [IW-1:0] issueA;
  logic [IW-1:0] issueB;
  logic          resultIn;
  logic          resultValid;
  logic          scanDone;
  logic          outValid;
  logic          outReady;
  logic [IW-1:0] outA;
  logic [IW-1:0] outB;
  logic [$clog2(FD+1)-1:0] fifoCount;
  logic [CW-1:0] testedCount;
  logic [CW-1:0] hitCount;
  logic [CW-1:0] dropCount;
  logic          overflowFlag;
  logic          protoErr;
  logic          doneOut;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          iv;
    logic [IW-1:0] a;
    logic [IW-1:0] b;
    logic          rv;
    logic          r;
    logic          sd;
    logic          rdy;
    logic          eValid;
    logic [IW-1:0] eA;
    logic [IW-1:0] eB;
    int            eCnt;
    int            eTested;
    int            eHit;
    int            eErr;
    int            eDone;
  } vec_t;

  vec_t vecs[$];

  im_hit_collector #(
    .IDX_WIDTH (IW),
    .FIFO_DEPTH(FD),
    .CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issueValid),
    .issue_idx_a    (issueA),
    .issue_idx_b    (issueB),
    .result_in      (resultIn),
    .result_valid_in(resultValid),
    .scan_done_in   (scanDone),
    .out_valid      (outValid),
    .out_ready      (outReady),
    .out_idx_a      (outA),
    .out_idx_b      (outB),
    .fifo_count     (fifoCount),
    .tested_count   (testedCount),
    .hit_count      (hitCount),
    .drop_count     (dropCount),
    .overflow       (overflowFlag),
    .proto_err      (protoErr),
    .done_out       (doneOut)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(logic iv, int a, int b, logic rv, logic r, logic sd, logic rdy,
                                 logic eValid, int eA, int eB, int eCnt, int eTested, int eHit,
                                 int eErr, int eDone);
    vec_t v;
    v.iv = iv; v.a = IW'(a); v.b = IW'(b); v.rv = rv; v.r = r; v.sd = sd; v.rdy = rdy;
    v.eValid = eValid; v.eA = IW'(eA); v.eB = IW'(eB); v.eCnt = eCnt;
    v.eTested = eTested; v.eHit = eHit; v.eErr = eErr; v.eDone = eDone;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input int a, input int b, input logic rv,
                               input logic r, input logic sd, input logic rdy);
    issueValid  = iv;
    issueA      = IW'(a);
    issueB      = IW'(b);
    resultValid = rv;
    resultIn    = r;
    scanDone    = sd;
    outReady    = rdy;
    tick();
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic eValid, input int eA, input int eB,
                          input int eCnt, input int eTested, input int eHit, input int eDrop,
                          input int eOvf, input int eErr, input int eDone);
    checkOutput({tag, ".valid"}, outValid, eValid);
    if (eValid) begin
      checkOutput({tag, ".idxA"}, outA, eA);
      checkOutput({tag, ".idxB"}, outB, eB);
    end
    checkOutput({tag, ".count"}, fifoCount, eCnt);
    checkOutput({tag, ".tested"}, testedCount, eTested);
    checkOutput({tag, ".hit"}, hitCount, eHit);
    checkOutput({tag, ".drop"}, dropCount, eDrop);
    checkOutput({tag, ".overflow"}, overflowFlag, eOvf);
    checkOutput({tag, ".protoErr"}, protoErr, eErr);
    checkOutput({tag, ".done"}, doneOut, eDone);
  endtask

  initial begin
    int expHead[$];

    rst = 1'b1;
    issueValid = 0; issueA = 0; issueB = 0;
    resultValid = 0; resultIn = 0; scanDone = 0; outReady = 0;

    //                iv  a   b rv r sd rdy   V  A  B cnt T H err done
    vecs.push_back(mkVec(0, 0, 0, 0,0,0,0,    0, 0, 0, 0, 0,0, 0,0));
    vecs.push_back(mkVec(1, 3, 7, 0,0,0,1,    0, 0, 0, 0, 0,0, 0,0));
    vecs.push_back(mkVec(0, 0, 0, 1,1,0,1,    1, 3, 7, 1, 1,1, 0,0));
    vecs.push_back(mkVec(0, 0, 0, 0,0,0,1,    0, 0, 0, 0, 1,1, 0,0));
    vecs.push_back(mkVec(1,10,11, 0,0,0,0,    0, 0, 0, 0, 1,1, 0,0));
    vecs.push_back(mkVec(1,12,13, 1,1,0,0,    1,10,11, 1, 2,2, 0,0));
    vecs.push_back(mkVec(1,14,15, 1,0,0,0,    1,10,11, 1, 3,2, 0,0));
    vecs.push_back(mkVec(1,16,17, 1,1,0,0,    1,10,11, 2, 4,3, 0,0));
    vecs.push_back(mkVec(1,18,19, 1,0,0,0,    1,10,11, 2, 5,3, 0,0));
    vecs.push_back(mkVec(0, 0, 0, 1,1,0,0,    1,10,11, 3, 6,4, 0,0));
    vecs.push_back(mkVec(0, 0, 0, 0,0,0,1,    1,14,15, 2, 6,4, 0,0));
    vecs.push_back(mkVec(0, 0, 0, 0,0,0,1,    1,18,19, 1, 6,4, 0,0));
    vecs.push_back(mkVec(0, 0, 0, 0,0,0,1,    0, 0, 0, 0, 6,4, 0,0));
    vecs.push_back(mkVec(0, 0, 0, 1,1,0,0,    0, 0, 0, 0, 6,4, 1,0));
    vecs.push_back(mkVec(0, 0, 0, 0,0,1,0,    0, 0, 0, 0, 6,4, 1,1));
    vecs.push_back(mkVec(1,30,31, 0,0,0,0,    0, 0, 0, 0, 6,4, 1,0));
    vecs.push_back(mkVec(0, 0, 0, 1,0,0,0,    0, 0, 0, 0, 7,4, 1,0));

    $display("[TB] reset and vector table");
    tick();
    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].iv, int'(vecs[i].a), int'(vecs[i].b), vecs[i].rv, vecs[i].r,
                    vecs[i].sd, vecs[i].rdy);
      checkAll($sformatf("row%0d", i), vecs[i].eValid, int'(vecs[i].eA), int'(vecs[i].eB),
               vecs[i].eCnt, vecs[i].eTested, vecs[i].eHit, 0, 0, vecs[i].eErr, vecs[i].eDone);
    end

    $display("[TB] double issue");
    doReset();
    applyStimulus(1, 20, 21, 0, 0, 0, 0);
    checkOutput("dbl.protoBefore", protoErr, 0);
    applyStimulus(1, 22, 23, 0, 0, 0, 0);
    checkOutput("dbl.protoAfter", protoErr, 1);
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    checkAll("dbl.hit", 1, 20, 21, 1, 1, 1, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkAll("dbl.popped", 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("dbl.noSecond", outValid, 0);

    $display("[TB] done while pending");
    applyStimulus(1, 5, 6, 0, 0, 0, 0);
    checkOutput("done.issued", doneOut, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("done.pendingScan", doneOut, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    checkOutput("done.queued", doneOut, 0);
    checkOutput("done.queuedCount", fifoCount, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("done.stillQueued", doneOut, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("done.drained", doneOut, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("done.held", doneOut, 1);
    applyStimulus(1, 8, 9, 0, 0, 0, 0);
    checkOutput("done.clearedByIssue", doneOut, 0);

    $display("[TB] overflow");
    doReset();
    checkAll("ovf.reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 100, 0, 0, 0, 0);
    for (int k = 1; k <= 18; k++) begin
      applyStimulus(1, k, k + 100, 1, 1, 0, 0);
    end
    checkAll("ovf.full", 1, 0, 100, 16, 18, 18, 2, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 1);
    checkAll("ovf.pushPop", 1, 1, 101, 16, 19, 19, 2, 1, 0, 0);
    for (int k = 1; k <= 15; k++) expHead.push_back(k);
    expHead.push_back(18);
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("ovf.drain%0d.a", k), outA, expHead[k]);
      checkOutput($sformatf("ovf.drain%0d.b", k), outB, expHead[k] + 100);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
    end
    checkAll("ovf.empty", 0, 0, 0, 0, 19, 19, 2, 1, 0, 0);

    $display("[TB] reset mid-operation");
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 40, 41, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 40 + 2 * k, 41 + 2 * k, 1, 1, 0, 0);
    end
    checkOutput("rst.queuedBefore", fifoCount, 4);
    checkOutput("rst.protoBefore", protoErr, 1);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    rst = 1'b0;
    checkAll("rst.after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    checkAll("rst.idleAfter", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
